// File: rtl/div_sequencer_if.sv
// Interfaces for the divide sequencer.
//   div_sequencer_if : request/response bus between a requester (master)
//                      and the sequencer (slave).
//   div_unit_if      : launch/result bus between the sequencer (master) and
//                      the iterative divider unit (slave).
interface div_sequencer_if #(parameter int WIDTH = 32);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [WIDTH-1:0] req_rs1;
   logic [WIDTH-1:0] req_rs2;
   logic             resp_valid;
   logic [WIDTH-1:0] resp_data;

   modport master (
      output req_valid, req_op, req_rs1, req_rs2,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2,
      output req_ready, resp_valid, resp_data
   );
endinterface

interface div_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic             sign;
   logic             stall;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divider;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             ready;

   modport master (
      output start, sign, stall, dividend, divider,
      input  quotient, remainder, ready
   );

   modport slave (
      input  start, sign, stall, dividend, divider,
      output quotient, remainder, ready
   );
endinterface

// File: rtl/div_sequencer.sv
// Divide/remainder sequencer in front of an iterative, non-resettable
// divider unit. Handles divide-by-zero and signed overflow without the
// divider, launches it otherwise, and returns a one-cycle response pulse.
// Optional feature macro: DIV_RESULT_CACHE_EN (single-entry result cache).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request
// LAUNCH | one-cycle start pulse to the divider
// WAIT   | divider busy; capture result on first ready
// DONE   | response pulse (held while stalled)
// DRAIN  | wait for an abandoned divider run to finish (flush / reset)
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           stall,
   input  logic           flush,
   div_sequencer_if.slave req,
   div_unit_if.master     div
);

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_DONE,
      S_DRAIN
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic             ready_int;
   logic             resp_valid_int;
   logic             start_int;
   logic             accept;
   logic             rs2_zero;
   logic             sgn_ovf;
   logic             short_path;
   logic             fill;
   logic             cache_hit;
   logic [WIDTH-1:0] cache_quot;
   logic [WIDTH-1:0] cache_rem;
   logic [WIDTH-1:0] short_quot;
   logic [WIDTH-1:0] short_rem;
   logic [WIDTH-1:0] short_data;

   logic [1:0]       op_q;
   logic [WIDTH-1:0] dividend_q;
   logic [WIDTH-1:0] divider_q;
   logic [WIDTH-1:0] resp_data_q;

   assign accept     = req.req_valid && ready_int;
   assign rs2_zero   = (req.req_rs2 == '0);
   assign sgn_ovf    = !req.req_op[0] && (req.req_rs1 == MIN_NEG) && (req.req_rs2 == '1);
   assign short_path = rs2_zero || sgn_ovf || cache_hit;
   assign fill       = (state == S_WAIT) && div.ready && !flush && !stall;

   // State register; reset lands in DRAIN because the divider may still be busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_DRAIN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a stall freezes the sequencer in place.
   always_comb begin
      state_nxt = state;
      if (!stall) begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state_nxt = short_path ? S_DONE : S_LAUNCH;
               end
            end
            S_LAUNCH: state_nxt = flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
               if (flush) begin
                  state_nxt = S_DRAIN;
               end else if (div.ready) begin
                  state_nxt = S_DONE;
               end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_DRAIN: begin
               if (div.ready) begin
                  state_nxt = S_IDLE;
               end
            end
            default: state_nxt = S_DRAIN;
         endcase
      end
   end

   // Moore-style outputs; flush blocks a same-cycle accept and kills a pending response.
   always_comb begin
      ready_int      = 1'b0;
      resp_valid_int = 1'b0;
      start_int      = 1'b0;
      case (state)
         S_IDLE:   ready_int      = !stall && !flush;
         S_LAUNCH: start_int      = 1'b1;
         S_DONE:   resp_valid_int = !flush;
         default:  ;
      endcase
   end

   // Results that bypass the divider: divide-by-zero, signed overflow, cache hit.
   always_comb begin
      short_quot = cache_quot;
      short_rem  = cache_rem;
      if (rs2_zero) begin
         short_quot = '1;
         short_rem  = req.req_rs1;
      end else if (sgn_ovf) begin
         short_quot = req.req_rs1;
         short_rem  = '0;
      end
      short_data = req.req_op[1] ? short_rem : short_quot;
   end

   // Operand/op capture on accept and result capture; operands stay put
   // because the divider's remainder is combinational on them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q        <= '0;
         dividend_q  <= '0;
         divider_q   <= '0;
         resp_data_q <= '0;
      end else if (!stall) begin
         if (accept) begin
            op_q       <= req.req_op;
            dividend_q <= req.req_rs1;
            divider_q  <= req.req_rs2;
            if (short_path) begin
               resp_data_q <= short_data;
            end
         end else if (fill) begin
            resp_data_q <= op_q[1] ? div.remainder : div.quotient;
         end
      end
   end

`ifdef DIV_RESULT_CACHE_EN
   logic             cache_valid;
   logic             cache_sign;
   logic [WIDTH-1:0] cache_rs1;
   logic [WIDTH-1:0] cache_rs2;
   logic [WIDTH-1:0] cache_quot_q;
   logic [WIDTH-1:0] cache_rem_q;

   // Single-entry cache of the last divider run; flush and reset drop it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_valid  <= 1'b0;
         cache_sign   <= 1'b0;
         cache_rs1    <= '0;
         cache_rs2    <= '0;
         cache_quot_q <= '0;
         cache_rem_q  <= '0;
      end else if (!stall) begin
         if (flush) begin
            cache_valid <= 1'b0;
         end else if (fill) begin
            cache_valid  <= 1'b1;
            cache_sign   <= ~op_q[0];
            cache_rs1    <= dividend_q;
            cache_rs2    <= divider_q;
            cache_quot_q <= div.quotient;
            cache_rem_q  <= div.remainder;
         end
      end
   end

   assign cache_hit  = cache_valid && (cache_rs1 == req.req_rs1) &&
                       (cache_rs2 == req.req_rs2) && (cache_sign == ~req.req_op[0]);
   assign cache_quot = cache_quot_q;
   assign cache_rem  = cache_rem_q;
`else
   assign cache_hit  = 1'b0;
   assign cache_quot = '0;
   assign cache_rem  = '0;
`endif

   assign req.req_ready  = ready_int;
   assign req.resp_valid = resp_valid_int;
   assign req.resp_data  = resp_data_q;

   assign div.start    = start_int;
   assign div.sign     = ~op_q[0];
   assign div.stall    = stall;
   assign div.dividend = dividend_q;
   assign div.divider  = divider_q;

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Port: CLK  input  1  clock; all state changes on rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous, active-high.
REQ-004 Port: STALL  input  1  pipeline stall; freezes sequencer and divider.
REQ-005 Port: FLUSH  input  1  abort in-flight operation.
REQ-006 Port: REQ_VALID  input  1  request present.
REQ-007 Port: REQ_READY  output  1  sequencer accepts request.
REQ-008 Port: REQ_OP  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-009 Port: REQ_RS1  input  WIDTH  dividend.
REQ-010 Port: REQ_RS2  input  WIDTH  divisor.
REQ-011 Port: RESP_VALID  output  1  one-cycle result pulse.
REQ-012 Port: RESP_DATA  output  WIDTH  result, valid when RESP_VALID.
REQ-013 Port: DIV_START  output  1  start to divider unit.
REQ-014 Port: DIV_SIGN  output  1  signed mode to divider (OP[0]==0).
REQ-015 Port: DIV_STALL  output  1  divider freeze, equals STALL.
REQ-016 Port: DIV_DIVIDEND  output  WIDTH  registered operand to divider.
REQ-017 Port: DIV_DIVIDER  output  WIDTH  registered operand to divider.
REQ-018 Port: DIV_QUOTIENT / DIV_REMAINDER  input  WIDTH each  divider results (two ports).
REQ-019 Port: DIV_READY  input  1  divider idle; low WIDTH cycles after sampling START.

Function
REQ-020 States SHALL be IDLE, LAUNCH, WAIT, DONE, DRAIN; REQ_READY=1 only in IDLE with STALL=0.
REQ-021 Accept (REQ_VALID&&REQ_READY at edge T) SHALL register op and operands; operands held on DIV_DIVIDEND/DIV_DIVIDER until the next accept, since divider remainder is combinational on them.
REQ-022 RS2==0 on accept SHALL go IDLE->DONE: quotient all-ones, remainder = RS1; divider not started.
REQ-023 Signed op with RS1=100..0 and RS2=all-ones SHALL go IDLE->DONE: quotient = RS1, remainder 0; divider not started.
REQ-024 Otherwise IDLE->LAUNCH; DIV_START=1 exactly one cycle (LAUNCH); LAUNCH->WAIT unconditionally; DIV_READY ignored in LAUNCH.
REQ-025 WAIT SHALL capture DIV_QUOTIENT (DIV/DIVU) or DIV_REMAINDER (REM/REMU) into RESP_DATA at the first edge with DIV_READY=1, ->DONE.
REQ-026 DONE SHALL assert RESP_VALID one cycle then ->IDLE; normal latency = WIDTH+2 cycles from accept to RESP_VALID (34 at WIDTH=32); special cases 1 cycle.
REQ-027 STALL=1 SHALL hold state, outputs and registers; RESP_VALID in DONE remains high until the first non-stalled edge.
REQ-028 FLUSH in LAUNCH/WAIT SHALL ->DRAIN, no RESP_VALID; in DONE SHALL suppress RESP_VALID ->IDLE; FLUSH beats a simultaneous accept in IDLE (no accept).
REQ-029 DRAIN SHALL hold DIV_START=0 and exit to IDLE at first edge with DIV_READY=1.

Reset
REQ-030 RST SHALL force DRAIN, REQ_READY=0, RESP_VALID=0, DIV_START=0, RESP_DATA=0, operand registers 0, result cache invalid; divider has no reset, so DRAIN covers reset mid-operation.

Configuration
REQ-031 Macro DIV_RESULT_CACHE_EN: when defined, last divider result (RS1, RS2, signedness, quotient, remainder) SHALL be stored; an accept matching all three SHALL go IDLE->DONE (1-cycle latency) without starting divider; FLUSH and RST invalidate; special cases not cached.
REQ-032 Without DIV_RESULT_CACHE_EN: no cache storage; every non-special op launches the divider.

Verification
REQ-033 DIV RS1=-7 RS2=2 -> DIV_START once, RESP_VALID 34 cycles after accept, RESP_DATA=-3; then REM same operands (cache off) -> RESP_DATA=-1 after 34 cycles.
REQ-034 DIVU RS1=5 RS2=0 -> RESP_DATA=0xFFFFFFFF next cycle; REMU same -> 5; DIV_START never asserted.
REQ-035 DIV RS1=0x80000000 RS2=0xFFFFFFFF -> RESP_DATA=0x80000000 in 1 cycle; REM same -> 0.
REQ-036 FLUSH 10 cycles after accept -> no RESP_VALID, REQ_READY low until DIV_READY high, next DIVU 100/7 -> 14.
REQ-037 RST asserted mid-WAIT, released -> REQ_READY stays 0 until DIV_READY=1; STALL 5 cycles during WAIT -> latency 39.
REQ-038 With DIV_RESULT_CACHE_EN: DIV 100/7 (34 cycles, 14) then REM 100/7 -> 2 in 1 cycle, DIV_START not pulsed.
